iccm_loader: RTL and testbench
==============================

// Module: iccm_loader
// PURPOSE
//  Boot-time program loader for the instruction memory. Assembles a byte stream (UART RX) into
//  32-bit little-endian words and writes them to consecutive ICCM word addresses via the
//  iccm_ctrl_* write port, holding the core in reset (prog_rst_no low) while loading.
//  Loading ends on a terminator word, address overflow, or abort; the core is then released.
// PARAMETERS
//  AW           12              ICCM word-address width; DEPTH = 2**AW words
//  END_WORD     32'h0000_0FFF   terminator word; ends load and is never written
//  TIMEOUT_CYC  50000           idle cycles allowed between bytes of one partial word
//  TW           16              timeout counter width; TIMEOUT_CYC < 2**TW
// PORTS
//  clk_i              in   1   clock
//  rst_i              in   1   synchronous reset, active-high
//  prog_en_i          in   1   level; high requests programming mode
//  rx_byte_i          in   8   received byte
//  rx_valid_i         in   1   1-cycle strobe, rx_byte_i valid; always accepted, no backpressure
//  iccm_ctrl_addr_o   out  AW  ICCM word address
//  iccm_ctrl_wdata_o  out  32  ICCM write data
//  iccm_ctrl_we_o     out  1   ICCM write strobe, 1 cycle per word
//  prog_rst_no        out  1   core program reset, active-low; low while loading
//  done_o             out  1   high in DONE
//  ovf_o              out  1   sticky: load hit last address
//  timeout_o          out  1   sticky: partial word discarded on timeout
//  word_cnt_o         out  AW+1 words written this load
// BEHAVIOUR
//  Reset: state=IDLE, addr=0, wdata=0, we=0, prog_rst_no=1, done=0, ovf=0, timeout=0,
//   word_cnt=0, byte_cnt=0, shift reg=0, timer=0. Reset mid-load aborts at once; no further writes.
//  States: IDLE, RECV, WRITE, DONE (registered; all outputs registered).
//  IDLE: prog_rst_no=1. prog_en_i=1 -> RECV next cycle; clear addr, word_cnt, byte_cnt, ovf,
//   timeout; prog_rst_no=0 from the cycle RECV is entered.
//  RECV: each rx_valid_i shifts sr <= {rx_byte_i, sr[31:8]} (first byte = bits 7:0); byte_cnt++.
//   On the 4th byte: assembled word == END_WORD -> DONE (no write); else latch it into wdata,
//   byte_cnt=0 -> WRITE.
//  WRITE: exactly 1 cycle, we=1 with addr/wdata stable. Next cycle: we=0, word_cnt++.
//   If addr == DEPTH-1: ovf=1 -> DONE (addr holds, no wrap). Else addr++ -> RECV.
//   rx_valid_i in WRITE is accepted as byte 0 of the next word (byte_cnt=1); no byte is dropped.
//  Timeout: in RECV with byte_cnt!=0, timer counts cycles without rx_valid_i; any byte clears it.
//   At timer == TIMEOUT_CYC: discard partial word, byte_cnt=0, timeout=1, stay RECV.
//   Timer is held at 0 when byte_cnt==0.
//  Abort: prog_en_i=0 in RECV or WRITE -> IDLE next cycle (a WRITE in progress completes its
//   single we cycle); partial word discarded, prog_rst_no=1, done stays 0.
//  DONE: done=1, prog_rst_no=1, we=0, rx ignored. Stays in DONE while prog_en_i=1;
//   prog_en_i=0 -> IDLE (done=0). A new load needs prog_en_i low then high.
//  Latency: 4th byte at cycle N -> we at N+1 -> addr increments at N+2.
//  word_cnt saturates at DEPTH. Flags clear only on reset or entry to a new load.
// TESTING
//  1. prog_en=1, bytes 13 05 00 00 | 93 05 10 00 | FF 0F 00 00 -> writes 0x00000513@0,
//     0x00100593@1; done=1, word_cnt=2, prog_rst_no low during load, high after.
//  2. Byte arrives in the WRITE cycle of word 0 -> counted as byte 0 of word 1; word 1 is
//     correct, no byte lost.
//  3. 2 bytes, then TIMEOUT_CYC idle cycles -> timeout=1, no write; next 4 bytes written @addr 0.
//  4. AW=3: 8 words sent -> 8 writes @0..7, ovf=1, done=1; extra bytes ignored, no 9th write.
//  5. prog_en dropped after 6 bytes -> IDLE, 1 word written, prog_rst_no=1, done=0;
//     prog_en again -> load restarts @addr 0.
//  6. rst_i during RECV with 3 bytes held -> all outputs at reset values next cycle, no write.

Source files
------------

// File: rtl/iccm_loader.sv
// iccm_loader: boot-time program loader. Packs a UART byte stream into
// little-endian 32-bit words and writes them to consecutive ICCM word
// addresses while holding the core in reset. A load ends on the terminator
// word, after the last address is written, or when prog_en_i drops.
module iccm_loader #(
  parameter int unsigned AW          = 12,
  parameter logic [31:0] END_WORD    = 32'h0000_0FFF,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TW          = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          prog_en_i,
  input  logic [7:0]    rx_byte_i,
  input  logic          rx_valid_i,
  output logic [AW-1:0] iccm_ctrl_addr_o,
  output logic [31:0]   iccm_ctrl_wdata_o,
  output logic          iccm_ctrl_we_o,
  output logic          prog_rst_no,
  output logic          done_o,
  output logic          ovf_o,
  output logic          timeout_o,
  output logic [AW:0]   word_cnt_o
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR   = '1;
  localparam logic [AW:0]   DEPTH_CNT   = {1'b1, {AW{1'b0}}};
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYC);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          prst_n_q, prst_n_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          timeout_q, timeout_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [1:0]    bcnt_q, bcnt_d;
  // Holds up to three earlier bytes of the current word; the fourth byte is
  // combined on arrival, so the low byte of a full 32-bit shifter is never needed.
  logic [23:0]   sr_q, sr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   shifted;

  assign shifted = {rx_byte_i, sr_q};

  // Next-state and next-output logic for every register.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    prst_n_d  = prst_n_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    timeout_d = timeout_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    sr_d      = sr_q;
    timer_d   = timer_q;

    case (state_q)
      IDLE: begin
        prst_n_d = 1'b1;
        done_d   = 1'b0;
        if (prog_en_i) begin
          state_d   = RECV;
          addr_d    = '0;
          wcnt_d    = '0;
          bcnt_d    = '0;
          ovf_d     = 1'b0;
          timeout_d = 1'b0;
          sr_d      = '0;
          timer_d   = '0;
          prst_n_d  = 1'b0;
        end
      end

      RECV: begin
        if (!prog_en_i) begin
          state_d  = IDLE;
          prst_n_d = 1'b1;
          bcnt_d   = '0;
          sr_d     = '0;
          timer_d  = '0;
        end else if (rx_valid_i) begin
          timer_d = '0;
          if (bcnt_q == 2'd3) begin
            bcnt_d = '0;
            sr_d   = '0;
            if (shifted == END_WORD) begin
              state_d  = DONE;
              done_d   = 1'b1;
              prst_n_d = 1'b1;
            end else begin
              state_d = WRITE;
              wdata_d = shifted;
              we_d    = 1'b1;
            end
          end else begin
            sr_d   = shifted[31:8];
            bcnt_d = bcnt_q + 2'd1;
          end
        end else if (bcnt_q != 2'd0) begin
          if (timer_q == TIMEOUT_VAL) begin
            bcnt_d    = '0;
            sr_d      = '0;
            timer_d   = '0;
            timeout_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      WRITE: begin
        // The write strobe was already issued this cycle, so it is counted
        // even when the load is being aborted.
        if (wcnt_q != DEPTH_CNT) wcnt_d = wcnt_q + (AW+1)'(1);
        if (!prog_en_i) begin
          state_d  = IDLE;
          prst_n_d = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d  = DONE;
          ovf_d    = 1'b1;
          done_d   = 1'b1;
          prst_n_d = 1'b1;
        end else begin
          state_d = RECV;
          addr_d  = addr_q + AW'(1);
          // A byte landing during the write cycle starts the next word.
          if (rx_valid_i) begin
            sr_d   = shifted[31:8];
            bcnt_d = 2'd1;
          end
        end
      end

      DONE: begin
        done_d   = 1'b1;
        prst_n_d = 1'b1;
        if (!prog_en_i) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      prst_n_q  <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      sr_q      <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      prst_n_q  <= prst_n_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      sr_q      <= sr_d;
      timer_q   <= timer_d;
    end
  end

  assign iccm_ctrl_addr_o  = addr_q;
  assign iccm_ctrl_wdata_o = wdata_q;
  assign iccm_ctrl_we_o    = we_q;
  assign prog_rst_no       = prst_n_q;
  assign done_o            = done_q;
  assign ovf_o             = ovf_q;
  assign timeout_o         = timeout_q;
  assign word_cnt_o        = wcnt_q;

endmodule

// File: tb/tb_iccm_loader.sv
// tb_iccm_loader: drives byte streams into iccm_loader (AW=3, short timeout)
// and compares the captured ICCM writes and status flags against a
// word-level model of the load.
module tb_iccm_loader;

  localparam int          AW       = 3;
  localparam int          DEPTH    = 8;
  localparam int          TO       = 40;
  localparam logic [31:0] END_WORD = 32'h0000_0FFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_en = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          we, prog_rst_no, done, ovf, timeout;
  logic [AW:0]   word_cnt;

  iccm_loader #(.AW(AW), .END_WORD(END_WORD), .TIMEOUT_CYC(TO), .TW(16)) dut (
    .clk_i(clk), .rst_i(rst), .prog_en_i(prog_en), .rx_byte_i(rx_byte),
    .rx_valid_i(rx_valid), .iccm_ctrl_addr_o(addr), .iccm_ctrl_wdata_o(wdata),
    .iccm_ctrl_we_o(we), .prog_rst_no(prog_rst_no), .done_o(done), .ovf_o(ovf),
    .timeout_o(timeout), .word_cnt_o(word_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Write capture: every strobed write, plus writes seen with the core released.
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];
  int            rst_hi_writes = 0;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      obs_addr.push_back(addr);
      obs_data.push_back(wdata);
      if (prog_rst_no !== 1'b0) rst_hi_writes++;
    end
  end

  // Reference model: byte stream -> expected written words.
  logic [7:0]  bytes_q[$];
  logic [31:0] exp_q[$];
  bit          exp_ovf, exp_term;

  task automatic model_load();
    logic [31:0] w;
    exp_q.delete();
    exp_ovf  = 0;
    exp_term = 0;
    for (int i = 0; i + 3 < bytes_q.size(); i += 4) begin
      w = {bytes_q[i+3], bytes_q[i+2], bytes_q[i+1], bytes_q[i]};
      if (w == END_WORD) begin exp_term = 1; break; end
      exp_q.push_back(w);
      if (exp_q.size() == DEPTH) begin exp_ovf = 1; break; end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) bytes_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_stream(input int maxgap);
    foreach (bytes_q[i]) send_byte(bytes_q[i], $urandom_range(0, maxgap));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom(); while (w == END_WORD);
    return w;
  endfunction

  task automatic start_load();
    obs_addr.delete();
    obs_data.delete();
    bytes_q.delete();
    prog_en = 1'b1;
    tick(1);
  endtask

  task automatic end_load();
    prog_en = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_cmp++;
    if ({addr, wdata, we, prog_rst_no, done, ovf, timeout, word_cnt} !==
        {3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%h/%b%b%b%b%b/%0d want 0/0/0101 0 0/0",
               addr, wdata, we, prog_rst_no, done, ovf, timeout, word_cnt);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    start_load();
    n_cmp++;
    if (prog_rst_no !== 1'b0) begin n_bad++; $display("FAIL basic_core_held: got %b want 0", prog_rst_no); end
    send_byte(8'h13, 1); send_byte(8'h05, 1); send_byte(8'h00, 1); send_byte(8'h00, 0);
    n_cmp++;
    if ({we, addr, wdata} !== {1'b1, 3'd0, 32'h0000_0513}) begin
      n_bad++; $display("FAIL basic_we_latency: got we=%b addr=%0d data=%h want 1/0/00000513", we, addr, wdata);
    end
    tick(1);
    n_cmp++;
    if ({we, addr, word_cnt} !== {1'b0, 3'd1, 4'd1}) begin
      n_bad++; $display("FAIL basic_addr_incr: got we=%b addr=%0d cnt=%0d want 0/1/1", we, addr, word_cnt);
    end
    send_word(32'h0010_0593, 1);
    send_word(END_WORD, 1);
    tick(2);
    n_cmp++;
    if (obs_data.size() !== 2 || obs_addr[0] !== 3'd0 || obs_data[0] !== 32'h0000_0513 ||
        obs_addr[1] !== 3'd1 || obs_data[1] !== 32'h0010_0593) begin
      n_bad++; $display("FAIL basic_writes: got n=%0d %h@%0d %h@%0d want 2 00000513@0 00100593@1",
                        obs_data.size(), obs_data[0], obs_addr[0], obs_data[1], obs_addr[1]);
    end
    n_cmp++;
    if ({done, prog_rst_no, word_cnt, ovf} !== {1'b1, 1'b1, 4'd2, 1'b0}) begin
      n_bad++; $display("FAIL basic_end: got done=%b rstn=%b cnt=%0d ovf=%b want 1/1/2/0", done, prog_rst_no, word_cnt, ovf);
    end
    n_cmp++;
    if (rst_hi_writes !== 0) begin n_bad++; $display("FAIL basic_rst_during_write: got %0d want 0", rst_hi_writes); end
    end_load();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_clear: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    w0 = rand_word();
    w1 = rand_word();
    start_load();
    send_word(w0, 0);
    send_word(w1, 0);
    send_word(END_WORD, 0);
    tick(2);
    n_cmp++;
    if (obs_data.size() !== 2 || obs_data[0] !== w0 || obs_data[1] !== w1 || obs_addr[1] !== 3'd1) begin
      n_bad++; $display("FAIL b2b_writes: got n=%0d %h %h@%0d want 2 %h %h@1",
                        obs_data.size(), obs_data[0], obs_data[1], obs_addr[1], w0, w1);
    end
    end_load();
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    w = rand_word();
    start_load();
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    tick(TO / 2);
    n_cmp++;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", timeout); end
    tick(TO);
    n_cmp++;
    if (timeout !== 1'b1 || obs_data.size() !== 0) begin
      n_bad++; $display("FAIL timeout_fire: got to=%b writes=%0d want 1/0", timeout, obs_data.size());
    end
    send_word(w, 1);
    send_word(END_WORD, 1);
    tick(2);
    n_cmp++;
    if (obs_data.size() !== 1 || obs_addr[0] !== 3'd0 || obs_data[0] !== w || timeout !== 1'b1 || done !== 1'b1) begin
      n_bad++; $display("FAIL timeout_recover: got n=%0d %h@%0d to=%b done=%b want 1 %h@0 1 1",
                        obs_data.size(), obs_data[0], obs_addr[0], timeout, done, w);
    end
    end_load();
  endtask

  task automatic test_overflow();
    start_load();
    for (int i = 0; i < DEPTH; i++) push_word(rand_word());
    for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom()));
    model_load();
    send_stream(2);
    tick(3);
    n_cmp++;
    if (obs_data.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL ovf_nwrites: got %0d want %0d", obs_data.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      n_cmp++;
      if (obs_addr[k] !== AW'(k) || obs_data[k] !== exp_q[k]) begin
        n_bad++; $display("FAIL ovf_write%0d: got %h@%0d want %h@%0d", k, obs_data[k], obs_addr[k], exp_q[k], k);
      end
    end
    n_cmp++;
    if ({ovf, done, word_cnt, addr, prog_rst_no} !== {1'b1, 1'b1, 4'd8, 3'd7, 1'b1}) begin
      n_bad++; $display("FAIL ovf_flags: got ovf=%b done=%b cnt=%0d addr=%0d rstn=%b want 1/1/8/7/1",
                        ovf, done, word_cnt, addr, prog_rst_no);
    end
    end_load();
  endtask

  task automatic test_abort();
    logic [31:0] w0, w1;
    w0 = rand_word();
    w1 = rand_word();
    start_load();
    send_word(w0, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    prog_en = 1'b0;
    tick(1);
    n_cmp++;
    if ({prog_rst_no, done, word_cnt} !== {1'b1, 1'b0, 4'd1}) begin
      n_bad++; $display("FAIL abort_state: got rstn=%b done=%b cnt=%0d want 1/0/1", prog_rst_no, done, word_cnt);
    end
    tick(3);
    n_cmp++;
    if (obs_data.size() !== 1 || obs_data[0] !== w0) begin
      n_bad++; $display("FAIL abort_writes: got n=%0d %h want 1 %h", obs_data.size(), obs_data[0], w0);
    end
    start_load();
    send_word(w1, 1);
    send_word(END_WORD, 1);
    tick(2);
    n_cmp++;
    if (obs_data.size() !== 1 || obs_addr[0] !== 3'd0 || obs_data[0] !== w1 || word_cnt !== 4'd1) begin
      n_bad++; $display("FAIL abort_restart: got n=%0d %h@%0d cnt=%0d want 1 %h@0 1",
                        obs_data.size(), obs_data[0], obs_addr[0], word_cnt, w1);
    end
    end_load();
  endtask

  task automatic test_reset_midload();
    start_load();
    send_byte(8'hDE, 1);
    send_byte(8'hAD, 1);
    send_byte(8'hBE, 1);
    rst = 1'b1;
    prog_en = 1'b0;
    tick(1);
    n_cmp++;
    if ({addr, wdata, we, prog_rst_no, done, ovf, timeout, word_cnt} !==
        {3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL midload_reset: got %h/%h/%b%b%b%b%b/%0d want 0/0/0101 0 0/0",
               addr, wdata, we, prog_rst_no, done, ovf, timeout, word_cnt);
    end
    rst = 1'b0;
    tick(3);
    n_cmp++;
    if (obs_data.size() !== 0) begin n_bad++; $display("FAIL midload_nowrite: got %0d want 0", obs_data.size()); end
  endtask

  task automatic test_random();
    int nw;
    for (int t = 0; t < 6; t++) begin
      start_load();
      nw = $urandom_range(1, 10);
      for (int i = 0; i < nw; i++) push_word(rand_word());
      if (nw <= DEPTH) push_word(END_WORD);
      model_load();
      send_stream(3);
      tick(3);
      n_cmp++;
      if (obs_data.size() !== exp_q.size()) begin
        n_bad++; $display("FAIL rand%0d_nwrites: got %0d want %0d", t, obs_data.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
        n_cmp++;
        if (obs_addr[k] !== AW'(k) || obs_data[k] !== exp_q[k]) begin
          n_bad++; $display("FAIL rand%0d_write%0d: got %h@%0d want %h@%0d", t, k, obs_data[k], obs_addr[k], exp_q[k], k);
        end
      end
      n_cmp++;
      if ({done, ovf, word_cnt, prog_rst_no} !== {1'b1, exp_ovf, 4'(exp_q.size()), 1'b1}) begin
        n_bad++; $display("FAIL rand%0d_flags: got done=%b ovf=%b cnt=%0d rstn=%b want 1/%b/%0d/1",
                          t, done, ovf, word_cnt, prog_rst_no, exp_ovf, exp_q.size());
      end
      end_load();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_abort();
    test_reset_midload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
